// File: rtl/booth_r4_pkg.sv
// booth_r4_pkg: shared types and sizing helpers for the radix-4 Booth multiplier.
//   state_t   - controller states, IDLE through DONE
//   digit_t   - recoded Booth digit, one of {0, +1, +2, -1, -2}
//   booth_k   - number of RUN iterations for an operand width
//   booth_cnt_w - width of the iteration counter
package booth_r4_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD_M,
    S_LD_Q,
    S_RUN,
    S_OUT_HI,
    S_OUT_LO,
    S_DONE
  } state_t;

  typedef enum logic [2:0] {
    D_ZERO,
    D_POS1,
    D_POS2,
    D_NEG1,
    D_NEG2
  } digit_t;

  // Operands are extended to w+2 bits and consumed two bits per cycle,
  // so w/2+1 digits cover them. The final digit lets an unsigned MSB
  // contribute positively; for signed operands it always recodes to zero.
  function automatic int booth_k(input int w);
    return w / 2 + 1;
  endfunction

  function automatic int booth_cnt_w(input int w);
    return $clog2(w / 2 + 2);
  endfunction

endpackage

// File: rtl/booth_r4_if.sv
// booth_r4_if: operand/result bus shared with the other arithmetic units.
//   bgn  - start request          sgn  - 1 signed, 0 unsigned
//   ibus - operand in (M then Q)  obus - product out (high then low half)
//   busy - operation in flight    stop - result delivered, unit waiting
// master drives requests (bus owner / testbench), slave is the multiplier.
interface booth_r4_if #(
  parameter int W = 8
);
  logic         bgn;
  logic         sgn;
  logic [W-1:0] ibus;
  logic [W-1:0] obus;
  logic         busy;
  logic         stop;

  modport master (
    output bgn, sgn, ibus,
    input  obus, busy, stop
  );

  modport slave (
    input  bgn, sgn, ibus,
    output obus, busy, stop
  );
endinterface

// File: rtl/booth_r4_recoder.sv
// booth_r4_recoder: modified-Booth digit selection.
//   bits  in  {Q[1], Q[0], Q[-1]} of the current multiplier window
//   digit out recoded digit in {-2,-1,0,+1,+2}
// Purely combinational.
module booth_r4_recoder
  import booth_r4_pkg::*;
(
  input  logic [2:0] bits,
  output digit_t     digit
);

  always_comb begin
    digit = D_ZERO;
    case (bits)
      3'b001, 3'b010: digit = D_POS1;
      3'b011:         digit = D_POS2;
      3'b100:         digit = D_NEG2;
      3'b101, 3'b110: digit = D_NEG1;
      default:        digit = D_ZERO;
    endcase
  end

endmodule

// File: rtl/booth_r4.sv
// booth_r4: sequential radix-4 Booth multiplier, W x W -> 2W bits.
//   clk   in  rising-edge clock
//   rst_b in  asynchronous active-low reset
//   bus   slave side of booth_r4_if (bgn/sgn/ibus in, obus/busy/stop out)
// Operation: bgn in IDLE/DONE starts; M is taken from ibus in LD_M, Q in
// LD_Q; RUN retires one Booth digit per cycle for W/2+1 cycles; the
// product leaves on obus as high half (OUT_HI) then low half (OUT_LO);
// DONE raises stop until the next accepted bgn.
module booth_r4
  import booth_r4_pkg::*;
#(
  parameter int W = 8
) (
  input  logic      clk,
  input  logic      rst_b,
  booth_r4_if.slave bus
);

  localparam int K  = booth_k(W);
  localparam int CW = booth_cnt_w(W);
  localparam int AW = W + 2;

  generate
    if (W < 4 || (W % 2) != 0) begin : g_bad_w
      $error("booth_r4: W must be even and >= 4");
    end
  endgenerate

  state_t          state, state_nxt;
  logic            mode;
  logic [AW-1:0]   m_r;
  logic [AW-1:0]   a_r;
  logic [AW-1:0]   q_r;
  logic            q_m1;
  logic [CW-1:0]   cnt;

  digit_t          dig;
  logic [AW-1:0]   addend;
  logic            cin;
  logic [AW-1:0]   sum;
  logic            last_iter;
  logic [AW-1:0]   ibus_ext;

  // ---------------------------------------------------------------------
  // Digit recode and W+2-bit add/subtract.
  // After each shift |A| < |M| and the sign of A is tied to the window's
  // low bit, so A + d*M stays inside (-2|M|, 2|M|): W+2 bits never wrap,
  // even for an unsigned 2^W-1 multiplicand.
  // ---------------------------------------------------------------------
  booth_r4_recoder u_rec (
    .bits  ({q_r[1:0], q_m1}),
    .digit (dig)
  );

  always_comb begin
    addend = '0;
    cin    = 1'b0;
    case (dig)
      D_POS1: addend = m_r;
      D_POS2: addend = m_r << 1;
      D_NEG1: begin
        addend = ~m_r;
        cin    = 1'b1;
      end
      D_NEG2: begin
        addend = ~(m_r << 1);
        cin    = 1'b1;
      end
      default: addend = '0;
    endcase
  end

  assign sum = a_r + addend + {{(AW-1){1'b0}}, cin};

  assign last_iter = (cnt == CW'(K - 1));

  // Operand extension follows the latched mode, not the live sgn pin.
  assign ibus_ext = mode ? {{2{bus.ibus[W-1]}}, bus.ibus}
                         : {2'b00, bus.ibus};

  // ---------------------------------------------------------------------
  // Controller
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE,
      S_DONE:   if (bus.bgn) state_nxt = S_LD_M;
      S_LD_M:   state_nxt = S_LD_Q;
      S_LD_Q:   state_nxt = S_RUN;
      S_RUN:    if (last_iter) state_nxt = S_OUT_HI;
      S_OUT_HI: state_nxt = S_OUT_LO;
      S_OUT_LO: state_nxt = S_DONE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      mode <= 1'b0;
      m_r  <= '0;
      a_r  <= '0;
      q_r  <= '0;
      q_m1 <= 1'b0;
      cnt  <= '0;
    end else begin
      case (state)
        S_IDLE,
        S_DONE: if (bus.bgn) mode <= bus.sgn;
        S_LD_M: begin
          m_r  <= ibus_ext;
          a_r  <= '0;
          q_m1 <= 1'b0;
          cnt  <= '0;
        end
        S_LD_Q: q_r <= ibus_ext;
        S_RUN: begin
          // {A,Q,Q-1} >>> 2 with A replaced by the adder result.
          a_r  <= {{2{sum[AW-1]}}, sum[AW-1:2]};
          q_r  <= {sum[1:0], q_r[AW-1:2]};
          q_m1 <= q_r[1];
          cnt  <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Outputs, decoded from registers only (no input-to-output path).
  // After K iterations {A,Q} holds the 2W+4-bit product; Q carries the
  // low W+2 bits, so the 2W-bit result spans A[W-3:0] and all of Q.
  // ---------------------------------------------------------------------
  logic [W-1:0] prod_hi, prod_lo;

  assign prod_hi = {a_r[W-3:0], q_r[AW-1:W]};
  assign prod_lo = q_r[W-1:0];

  assign bus.obus = (state == S_OUT_HI) ? prod_hi :
                    (state == S_OUT_LO) ? prod_lo : '0;
  assign bus.busy = (state == S_LD_M) || (state == S_LD_Q) || (state == S_RUN) ||
                    (state == S_OUT_HI) || (state == S_OUT_LO);
  assign bus.stop = (state == S_DONE);

endmodule

// File: tb/tb_booth_r4.sv
// tb_booth_r4: scoreboard bench for booth_r4 at W=8 and W=16.
// Drivers push the expected product and completion cycle into a queue per
// DUT; monitors pop on each rising stop and compare the two obus halves
// seen in the preceding cycles plus the latency.
module tb_booth_r4;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  booth_r4_if #(.W(8))  b8 ();
  booth_r4_if #(.W(16)) b16 ();

  booth_r4 #(.W(8))  u8  (.clk(clk), .rst_b(rst_b), .bus(b8));
  booth_r4 #(.W(16)) u16 (.clk(clk), .rst_b(rst_b), .bus(b16));

  typedef struct {
    logic [15:0] hi;
    logic [15:0] lo;
    int          done_cyc;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer multiplication of the interpreted operands.
  function automatic logic [31:0] ref_prod(input int w, input logic s,
                                           input logic [15:0] m, input logic [15:0] q);
    longint one, mi, qi, p;
    one = 1;
    mi  = longint'(m) & ((one << w) - 1);
    qi  = longint'(q) & ((one << w) - 1);
    if (s && mi[w-1]) mi = mi - (one << w);
    if (s && qi[w-1]) qi = qi - (one << w);
    p = mi * qi;
    return 32'(p & ((one << (2 * w)) - 1));
  endfunction

  function automatic logic [15:0] pick(input int w);
    logic [15:0] v, msk;
    msk = 16'((32'd1 << w) - 1);
    case ($urandom_range(0, 7))
      0: v = '0;
      1: v = msk;
      2: v = 16'(32'd1 << (w - 1));
      3: v = msk >> 1;
      default: v = 16'($urandom);
    endcase
    return v & msk;
  endfunction

  // ------------------------------------------------------------------ W=8
  task automatic wait_stop8();
    int n = 0;
    while (b8.stop !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 40) begin
      checks++; errors++;
      $display("FAIL w8_timeout act=stop_low exp=stop_high");
    end
  endtask

  task automatic op8(input logic s, input logic [7:0] m, input logic [7:0] q, input bit poke);
    exp_t e;
    logic [31:0] p;
    p = ref_prod(8, s, {8'h0, m}, {8'h0, q});
    e.hi = {8'h0, p[15:8]};
    e.lo = {8'h0, p[7:0]};
    e.done_cyc = cyc + 1 + 8 / 2 + 5;
    q8.push_back(e);
    b8.bgn = 1'b1; b8.sgn = s;
    @(posedge clk); #1 b8.bgn = 1'b0; b8.sgn = 1'($urandom); b8.ibus = m;
    @(posedge clk); #1 b8.ibus = q;
    @(posedge clk); #1 b8.ibus = 8'($urandom);
    if (poke) begin
      b8.bgn = 1'b1; b8.sgn = ~s;
      @(posedge clk); #1 b8.bgn = 1'b1;
      @(posedge clk); #1 b8.bgn = 1'b0;
    end
    wait_stop8();
  endtask

  // ----------------------------------------------------------------- W=16
  task automatic wait_stop16();
    int n = 0;
    while (b16.stop !== 1'b1 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 60) begin
      checks++; errors++;
      $display("FAIL w16_timeout act=stop_low exp=stop_high");
    end
  endtask

  task automatic op16(input logic s, input logic [15:0] m, input logic [15:0] q);
    exp_t e;
    logic [31:0] p;
    p = ref_prod(16, s, m, q);
    e.hi = p[31:16];
    e.lo = p[15:0];
    e.done_cyc = cyc + 1 + 16 / 2 + 5;
    q16.push_back(e);
    b16.bgn = 1'b1; b16.sgn = s;
    @(posedge clk); #1 b16.bgn = 1'b0; b16.sgn = 1'($urandom); b16.ibus = m;
    @(posedge clk); #1 b16.ibus = q;
    @(posedge clk); #1 b16.ibus = 16'($urandom);
    wait_stop16();
  endtask

  // ------------------------------------------------------------- monitors
  initial begin : mon8
    logic [7:0] ob_d1, ob_d2;
    logic       st_d, bz_d1;
    exp_t       e;
    ob_d1 = '0; ob_d2 = '0; st_d = 1'b0; bz_d1 = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_b) begin
        ob_d1 = '0; ob_d2 = '0; st_d = 1'b0; bz_d1 = 1'b0;
      end else begin
        if (b8.stop && !st_d) begin
          if (q8.size() == 0) begin
            checks++; errors++;
            $display("FAIL w8_unexpected_stop act=stop exp=none");
          end else begin
            e = q8.pop_front();
            chk("w8_hi", {24'h0, ob_d2}, {16'h0, e.hi});
            chk("w8_lo", {24'h0, ob_d1}, {16'h0, e.lo});
            chk("w8_latency", cyc, e.done_cyc);
            chk("w8_busy_out_lo", {31'h0, bz_d1}, 32'd1);
            chk("w8_done_obus", {24'h0, b8.obus}, 32'd0);
            chk("w8_done_busy", {31'h0, b8.busy}, 32'd0);
          end
        end
        st_d = b8.stop; ob_d2 = ob_d1; ob_d1 = b8.obus; bz_d1 = b8.busy;
      end
    end
  end

  initial begin : mon16
    logic [15:0] ob_d1, ob_d2;
    logic        st_d;
    exp_t        e;
    ob_d1 = '0; ob_d2 = '0; st_d = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_b) begin
        ob_d1 = '0; ob_d2 = '0; st_d = 1'b0;
      end else begin
        if (b16.stop && !st_d) begin
          if (q16.size() == 0) begin
            checks++; errors++;
            $display("FAIL w16_unexpected_stop act=stop exp=none");
          end else begin
            e = q16.pop_front();
            chk("w16_hi", {16'h0, ob_d2}, {16'h0, e.hi});
            chk("w16_lo", {16'h0, ob_d1}, {16'h0, e.lo});
            chk("w16_latency", cyc, e.done_cyc);
          end
        end
        st_d = b16.stop; ob_d2 = ob_d1; ob_d1 = b16.obus;
      end
    end
  end

  // ------------------------------------------------------------- stimulus
  initial begin
    b8.bgn = 1'b0;  b8.sgn = 1'b0;  b8.ibus = '0;
    b16.bgn = 1'b0; b16.sgn = 1'b0; b16.ibus = '0;
    #1;
    chk("rst_w8_obus", {24'h0, b8.obus}, 32'd0);
    chk("rst_w8_busy", {31'h0, b8.busy}, 32'd0);
    chk("rst_w8_stop", {31'h0, b8.stop}, 32'd0);
    chk("rst_w16_obus", {16'h0, b16.obus}, 32'd0);
    chk("rst_w16_busy", {31'h0, b16.busy}, 32'd0);
    chk("rst_w16_stop", {31'h0, b16.stop}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_b = 1'b1;
    @(posedge clk); #1;

    // Directed W=8 cases; each op after the first starts in the first DONE cycle.
    op8(1'b1, 8'hF9, 8'h03, 1'b0);
    op8(1'b0, 8'hFF, 8'hFF, 1'b0);
    op8(1'b1, 8'hFF, 8'hFF, 1'b0);
    op8(1'b1, 8'h80, 8'h80, 1'b0);
    op8(1'b0, 8'h80, 8'h80, 1'b0);
    op8(1'b1, 8'h9C, 8'h37, 1'b1);   // bgn/sgn toggled during RUN
    op8(1'b0, 8'h05, 8'h06, 1'b0);   // back-to-back from DONE

    // Reset in the middle of RUN: outputs clear at once, then unit idles.
    b8.bgn = 1'b1; b8.sgn = 1'b1;
    @(posedge clk); #1 b8.bgn = 1'b0; b8.ibus = 8'h7B;
    @(posedge clk); #1 b8.ibus = 8'hC4;
    repeat (3) @(posedge clk);
    #2 rst_b = 1'b0;
    #1;
    chk("midrun_rst_obus", {24'h0, b8.obus}, 32'd0);
    chk("midrun_rst_busy", {31'h0, b8.busy}, 32'd0);
    chk("midrun_rst_stop", {31'h0, b8.stop}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_idle_busy", {31'h0, b8.busy}, 32'd0);
    chk("post_rst_idle_stop", {31'h0, b8.stop}, 32'd0);
    op8(1'b0, 8'hC3, 8'h5A, 1'b0);
    op8(1'b1, 8'hC3, 8'h5A, 1'b0);

    fork
      begin
        for (int i = 0; i < 5000; i++)
          op8(1'($urandom), 8'(pick(8)), 8'(pick(8)), 1'($urandom_range(0, 15) == 0));
      end
      begin
        op16(1'b1, 16'h7FFF, 16'h8000);
        op16(1'b0, 16'hFFFF, 16'hFFFF);
        op16(1'b1, 16'h8000, 16'h8000);
        for (int j = 0; j < 300; j++)
          op16(1'($urandom), pick(16), pick(16));
      end
    join

    repeat (4) @(posedge clk);
    #1;
    chk("w8_queue_drained", q8.size(), 32'd0);
    chk("w16_queue_drained", q16.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
